sign_restore: RTL and testbench

Sign-restoration stage for the 12-bit signed image-processing datapath. It captures the sign bit of each signed sample entering a magnitude-only processing section and stores it in an in-order sign FIFO. When the corresponding unsigned magnitude returns, it re-applies the sign to produce a registered two's-complement result. Upstream of the magnitude path it consumes signed samples; downstream it feeds signed consumers.

---
 rtl/sign_restore.sv | 114 +++++++++++
 tb/tb_sign_restore.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sign_restore.sv
// Sign-restoration stage: queues the sign of each signed sample and re-applies it,
// with saturation, to the matching unsigned magnitude when it returns.
module sign_restore #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sgn_valid,
  input  logic [WIDTH-1:0]         sgn_in,
  output logic                     sgn_ready,
  input  logic                     mag_valid,
  input  logic [WIDTH-1:0]         mag_in,
  output logic                     mag_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_sat,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clr_err,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [WIDTH-1:0] DATA_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  logic          sign_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          pop_sign;
  logic [WIDTH-1:0] res_data;
  logic          res_sat;

  assign sgn_ready = (count != FULL_CNT);
  assign mag_ready = (count != '0);
  assign push      = sgn_valid && sgn_ready;
  assign pop       = mag_valid && mag_ready;

  // Sign storage carries no reset; only entries between the pointers are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      sign_mem[wr_ptr] <= sgn_in[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Negative results may reach MIN_NEG exactly; positive ones stop at MAX_POS.
  always_comb begin
    pop_sign = sign_mem[rd_ptr];
    res_data = mag_in;
    res_sat  = 1'b0;
    if (!pop_sign) begin
      if (mag_in > MAX_POS) begin
        res_data = MAX_POS;
        res_sat  = 1'b1;
      end
    end else if (mag_in > MIN_NEG) begin
      res_data = MIN_NEG;
      res_sat  = 1'b1;
    end else begin
      res_data = ~mag_in + DATA_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= pop;
      if (pop) begin
        out_data <= res_data;
        out_sat  <= res_sat;
      end
    end
  end

  // A fresh error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (sgn_valid && !sgn_ready) overflow <= 1'b1;
      else if (clr_err)            overflow <= 1'b0;
      if (mag_valid && !mag_ready) underflow <= 1'b1;
      else if (clr_err)            underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sign_restore.sv
// Directed self-checking bench for sign_restore (WIDTH=12, DEPTH=8).
module tb_sign_restore;

  logic        clk;
  logic        rst_n;
  logic        sgn_valid;
  logic [11:0] sgn_in;
  logic        sgn_ready;
  logic        mag_valid;
  logic [11:0] mag_in;
  logic        mag_ready;
  logic        out_valid;
  logic [11:0] out_data;
  logic        out_sat;
  logic [3:0]  count;
  logic        clr_err;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;
  bit sign_q[$];

  sign_restore #(.WIDTH(12), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .sgn_valid(sgn_valid), .sgn_in(sgn_in), .sgn_ready(sgn_ready),
    .mag_valid(mag_valid), .mag_in(mag_in), .mag_ready(mag_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat),
    .count(count), .clr_err(clr_err),
    .overflow(overflow), .underflow(underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
  task automatic apply_stimulus(input logic sv, input logic [11:0] sd,
                                input logic mv, input logic [11:0] md, input logic clr);
    sgn_valid = sv;
    sgn_in    = sd;
    mag_valid = mv;
    mag_in    = md;
    clr_err   = clr;
    @(posedge clk);
    #1;
    sgn_valid = 1'b0;
    mag_valid = 1'b0;
    clr_err   = 1'b0;
  endtask

  // Reference result {sat, data} computed with plain integers.
  function automatic logic [12:0] model(input bit s, input logic [11:0] m);
    int mi;
    mi = int'(m);
    if (!s) begin
      if (mi > 2047) return {1'b1, 12'h7FF};
      return {1'b0, m};
    end
    if (mi > 2048) return {1'b1, 12'h800};
    return {1'b0, 12'((4096 - mi) % 4096)};
  endfunction

  logic [11:0] bnd_sgn [5];
  logic [11:0] bnd_mag [5];
  logic [11:0] bnd_exp [5];
  logic        bnd_sat [5];
  logic [11:0] ovf_val [9];
  logic [12:0] exp_res;
  logic [11:0] rs;
  logic [11:0] rm;
  bit          s_front;

  initial begin
    rst_n = 1'b0;
    sgn_valid = 1'b0; sgn_in = '0;
    mag_valid = 1'b0; mag_in = '0;
    clr_err = 1'b0;
    #12;
    $display("[TB] reset values");
    check_output("rst_sgn_ready", 16'(sgn_ready), 16'h1);
    check_output("rst_mag_ready", 16'(mag_ready), 16'h0);
    check_output("rst_count", 16'(count), 16'h0);
    check_output("rst_out_valid", 16'(out_valid), 16'h0);
    check_output("rst_out_data", 16'(out_data), 16'h0);
    check_output("rst_out_sat", 16'(out_sat), 16'h0);
    check_output("rst_overflow", 16'(overflow), 16'h0);
    check_output("rst_underflow", 16'(underflow), 16'h0);
    rst_n = 1'b1;

    $display("[TB] single round trip");
    apply_stimulus(1'b1, 12'hF38, 1'b0, 12'h000, 1'b0);
    check_output("rt_count_push", 16'(count), 16'h1);
    check_output("rt_mag_ready", 16'(mag_ready), 16'h1);
    apply_stimulus(1'b0, 12'h000, 1'b1, 12'h0C8, 1'b0);
    check_output("rt_out_valid", 16'(out_valid), 16'h1);
    check_output("rt_out_data", 16'(out_data), 16'hF38);
    check_output("rt_out_sat", 16'(out_sat), 16'h0);
    check_output("rt_count_pop", 16'(count), 16'h0);
    apply_stimulus(1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
    check_output("rt_idle_valid", 16'(out_valid), 16'h0);
    check_output("rt_idle_hold", 16'(out_data), 16'hF38);

    $display("[TB] boundary magnitudes");
    bnd_sgn = '{12'h800, 12'h000, 12'h7FF, 12'h005, 12'hFFD};
    bnd_mag = '{12'h800, 12'h000, 12'h7FF, 12'h800, 12'hFFF};
    bnd_exp = '{12'h800, 12'h000, 12'h7FF, 12'h7FF, 12'h800};
    bnd_sat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, bnd_sgn[i], 1'b0, 12'h000, 1'b0);
    check_output("bnd_count", 16'(count), 16'h5);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 12'h000, 1'b1, bnd_mag[i], 1'b0);
      check_output($sformatf("bnd_valid_%0d", i), 16'(out_valid), 16'h1);
      check_output($sformatf("bnd_data_%0d", i), 16'(out_data), 16'(bnd_exp[i]));
      check_output($sformatf("bnd_sat_%0d", i), 16'(out_sat), 16'(bnd_sat[i]));
    end

    $display("[TB] full and overflow");
    ovf_val = '{12'h900, 12'h100, 12'h200, 12'hA00, 12'hB00, 12'h300, 12'hC00, 12'h400, 12'hD00};
    for (int i = 0; i < 9; i++) apply_stimulus(1'b1, ovf_val[i], 1'b0, 12'h000, 1'b0);
    check_output("ovf_count", 16'(count), 16'h8);
    check_output("ovf_sgn_ready", 16'(sgn_ready), 16'h0);
    check_output("ovf_flag", 16'(overflow), 16'h1);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, 12'h000, 1'b1, 12'h001, 1'b0);
      check_output($sformatf("ovf_pop_data_%0d", i), 16'(out_data),
                   ovf_val[i][11] ? 16'h0FFF : 16'h0001);
    end
    check_output("ovf_drained_count", 16'(count), 16'h0);
    check_output("ovf_drained_mag_ready", 16'(mag_ready), 16'h0);
    check_output("ovf_no_underflow", 16'(underflow), 16'h0);
    apply_stimulus(1'b0, 12'h000, 1'b0, 12'h000, 1'b1);
    check_output("ovf_cleared", 16'(overflow), 16'h0);

    $display("[TB] underflow");
    apply_stimulus(1'b0, 12'h000, 1'b1, 12'h123, 1'b0);
    check_output("udf_flag", 16'(underflow), 16'h1);
    check_output("udf_no_valid", 16'(out_valid), 16'h0);
    apply_stimulus(1'b0, 12'h000, 1'b1, 12'h123, 1'b1);
    check_output("udf_err_wins", 16'(underflow), 16'h1);
    apply_stimulus(1'b0, 12'h000, 1'b0, 12'h000, 1'b1);
    check_output("udf_cleared", 16'(underflow), 16'h0);

    $display("[TB] streaming with wrap");
    for (int i = 0; i < 3; i++) begin
      rs = 12'($urandom);
      sign_q.push_back(rs[11]);
      apply_stimulus(1'b1, rs, 1'b0, 12'h000, 1'b0);
    end
    check_output("str_prefill_count", 16'(count), 16'h3);
    for (int i = 0; i < 40; i++) begin
      rs = 12'($urandom);
      rm = 12'($urandom);
      s_front = sign_q.pop_front();
      exp_res = model(s_front, rm);
      sign_q.push_back(rs[11]);
      apply_stimulus(1'b1, rs, 1'b1, rm, 1'b0);
      check_output($sformatf("str_valid_%0d", i), 16'(out_valid), 16'h1);
      check_output($sformatf("str_data_%0d", i), 16'(out_data), 16'(exp_res[11:0]));
      check_output($sformatf("str_sat_%0d", i), 16'(out_sat), 16'(exp_res[12]));
      check_output($sformatf("str_count_%0d", i), 16'(count), 16'h3);
    end
    check_output("str_overflow", 16'(overflow), 16'h0);
    check_output("str_underflow", 16'(underflow), 16'h0);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 2; i++) begin
      rs = 12'($urandom);
      sign_q.push_back(rs[11]);
      apply_stimulus(1'b1, rs, 1'b0, 12'h000, 1'b0);
    end
    s_front = sign_q.pop_front();
    exp_res = model(s_front, 12'h456);
    apply_stimulus(1'b1, 12'h000, 1'b1, 12'h456, 1'b0);
    check_output("mid_count", 16'(count), 16'h5);
    check_output("mid_valid", 16'(out_valid), 16'h1);
    check_output("mid_data", 16'(out_data), 16'(exp_res[11:0]));
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_valid", 16'(out_valid), 16'h0);
    check_output("mid_rst_count", 16'(count), 16'h0);
    check_output("mid_rst_mag_ready", 16'(mag_ready), 16'h0);
    #1;
    rst_n = 1'b1;
    sign_q.delete();
    apply_stimulus(1'b0, 12'h000, 1'b1, 12'h010, 1'b0);
    check_output("mid_post_underflow", 16'(underflow), 16'h1);
    check_output("mid_post_no_valid", 16'(out_valid), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
